max_pool_2x2_stride_2: RTL
==========================

// Module: max_pool_2x2_stride_2
// PURPOSE
//  Streaming 2x2 max-pool with stride 2 on IEEE-754 fp32 pixels.
//  Sits directly downstream of the 3x3 padded convolution stage and consumes its
//  Data_Out/Valid_Out raster stream (IMG_WIDHT x IMG_HEIGHT per frame, row-major).
//  Emits a (IMG_WIDHT/2) x (IMG_HEIGHT/2) raster stream for the next layer.
// PARAMETERS
//  IMG_WIDHT   30  input frame width in pixels; must be even
//  IMG_HEIGHT  30  input frame height in pixels; must be even
// PORTS
//  clk         in   1   single clock; all logic rising-edge
//  rst         in   1   asynchronous, active-low reset
//  Data_In     in   32  fp32 pixel from the convolution stage
//  Valid_In    in   1   Data_In qualifier; gaps of any length allowed
//  Data_Out    out  32  fp32 pooled pixel
//  Valid_Out   out  1   one-cycle qualifier per pooled pixel
//  Frame_Done  out  1   one-cycle pulse coincident with the last pooled pixel of a frame
// BEHAVIOUR
//  - Reset (rst=0, async): Data_Out=0, Valid_Out=0, Frame_Done=0, col/row counters=0,
//    pair register cleared. Row buffer contents are don't-care. Reset mid-frame discards
//    the partial frame; the first Valid_In after release is pixel (0,0).
//  - Counters: col 0..IMG_WIDHT-1 and row 0..IMG_HEIGHT-1 advance only on Valid_In.
//    col wraps to 0 and increments row; row wraps to 0 at frame end. No idle gap between frames.
//  - Even col: latch pixel in pair_reg. Odd col: h = max(pair_reg, Data_In).
//  - Even row, odd col: row_buf[col>>1] <= h. No output.
//  - Odd row, odd col: Data_Out <= max(h, row_buf[col>>1]), Valid_Out=1, registered.
//    Latency is 1 clk after the Valid_In beat carrying the bottom-right pixel of the window.
//  - Frame_Done=1 in the same cycle as the Valid_Out for window (W/2-1, H/2-1).
//  - Valid_Out/Frame_Done are 0 in every other cycle. Data_Out holds its last value when Valid_Out=0.
//  - Outputs per frame: exactly (IMG_WIDHT/2)*(IMG_HEIGHT/2). No backpressure; the consumer must accept every beat.
//  - fp32 max, combinational, defined on bit patterns:
//    * signs differ: the sign=0 operand wins (+0.0 beats -0.0).
//    * both sign=0: the larger {exp,mant} wins.
//    * both sign=1: the smaller {exp,mant} wins.
//    * equal patterns: either operand; the result is identical.
//    * NaN inputs are not supported; the result is whatever the rule above gives, with no trap.
//  - row_buf: IMG_WIDHT/2 x 32 entries. It is written on even rows and read on odd rows at the
//    same index, so there is no read/write collision.
// CONFIGURATION
//  RELU_FUSE_EN defined: a pooled result with sign=1 (including -0.0) is output as 32'h0000_0000.
//    No change in latency or in Valid_Out timing.
//  RELU_FUSE_EN undefined: the pooled result is output unmodified.
// STRUCTURE
//  Shared package (cnn_pkg): FP32_W=32, FP32_SIGN_BIT=31, FP32_POS_ZERO=32'h0, fp32 field slices.
//  Sub-module fp32_max2: combinational 2-input fp32 max per the rule above.
//    Instantiate it twice: horizontal max and vertical max.
//  Top level: counters, pair_reg, row_buf (inferred distributed RAM), output registers.
// TESTING
//  1 4x4 frame, pixels 1.0..16.0 in raster order -> 4 outputs 6.0,8.0,14.0,16.0; Frame_Done on the 4th.
//  2 4x2 frame, window values -1.0,-2.0,-3.0,-0.5 -> -0.5 (32'hBF00_0000); 32'h0 with RELU_FUSE_EN.
//  3 +0.0 vs -0.0 in the same window with all others negative -> 32'h0000_0000.
//  4 Valid_In toggled randomly (~50%) over two back-to-back 30x30 frames -> 225 outputs each,
//    matching the golden model, with two Frame_Done pulses.
//  5 rst asserted mid-row-17 of a 30x30 frame, then a full frame -> all outputs 0 during reset,
//    then exactly 225 correct outputs.
//  6 Valid_Out latency check -> high exactly 1 clk after each odd-row/odd-col input beat,
//    and never otherwise.

Source files
------------

// File: rtl/max_pool_2x2_stride_2_pkg.sv
// Shared fp32 definitions for the 2x2/stride-2 max-pool slice.
//   FP32_W / FP32_SIGN_BIT / FP32_POS_ZERO : word width, sign position, +0.0 pattern
//   fp32_sign / fp32_exp / fp32_mant / fp32_mag : field slices of an fp32 word
package max_pool_2x2_stride_2_pkg;

  localparam int FP32_W        = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MANT_W   = 23;

  typedef logic [FP32_W-1:0] fp32_t;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;

  function automatic logic fp32_sign(input fp32_t v);
    return v[FP32_SIGN_BIT];
  endfunction

  function automatic logic [FP32_EXP_W-1:0] fp32_exp(input fp32_t v);
    return v[FP32_SIGN_BIT-1 -: FP32_EXP_W];
  endfunction

  function automatic logic [FP32_MANT_W-1:0] fp32_mant(input fp32_t v);
    return v[FP32_MANT_W-1:0];
  endfunction

  // {exp,mant}: for equal signs this orders magnitudes as an unsigned integer
  function automatic logic [FP32_SIGN_BIT-1:0] fp32_mag(input fp32_t v);
    return {fp32_exp(v), fp32_mant(v)};
  endfunction

endpackage

// File: rtl/max_pool_2x2_stride_2_if.sv
// Pixel stream bundle between the convolution stage, the pooler and the next layer.
//   Data_In/Valid_In                  : fp32 input pixel and its qualifier
//   Data_Out/Valid_Out/Frame_Done     : pooled pixel, its qualifier, end-of-frame pulse
//   master : stream source / result sink side
//   slave  : pooler side
interface max_pool_2x2_stride_2_if;
  import max_pool_2x2_stride_2_pkg::*;

  fp32_t Data_In;
  logic  Valid_In;
  fp32_t Data_Out;
  logic  Valid_Out;
  logic  Frame_Done;

  modport master (
    output Data_In, Valid_In,
    input  Data_Out, Valid_Out, Frame_Done
  );

  modport slave (
    input  Data_In, Valid_In,
    output Data_Out, Valid_Out, Frame_Done
  );

endinterface

// File: rtl/max_pool_2x2_stride_2_fp32_max2.sv
// Combinational two-input fp32 maximum on raw bit patterns (no NaN handling).
//   a_i, b_i : operands
//   max_o    : larger operand; +0.0 beats -0.0, equal patterns pass a_i
module fp32_max2
  import max_pool_2x2_stride_2_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t max_o
);

  always_comb begin
    max_o = a_i;
    if (fp32_sign(a_i) != fp32_sign(b_i)) begin
      max_o = fp32_sign(a_i) ? b_i : a_i;
    end else if (!fp32_sign(a_i)) begin
      max_o = (fp32_mag(b_i) > fp32_mag(a_i)) ? b_i : a_i;
    end else begin
      // both negative: smaller magnitude is the larger value
      max_o = (fp32_mag(b_i) < fp32_mag(a_i)) ? b_i : a_i;
    end
  end

endmodule

// File: rtl/max_pool_2x2_stride_2.sv
// Streaming 2x2 max-pool, stride 2, on an fp32 raster stream.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   pool : slave side of max_pool_2x2_stride_2_if
// Build option: define RELU_FUSE_EN to clamp negative pooled results (incl. -0.0) to +0.0.
module max_pool_2x2_stride_2
  import max_pool_2x2_stride_2_pkg::*;
#(
  parameter int IMG_WIDHT  = 30,
  parameter int IMG_HEIGHT = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  max_pool_2x2_stride_2_if.slave  pool
);

  localparam int COL_W = (IMG_WIDHT  > 2) ? $clog2(IMG_WIDHT)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BUF_D = IMG_WIDHT / 2;
  localparam int IDX_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  fp32_t            pair_q, pair_d;
  fp32_t            dout_q, dout_d;
  logic             vout_q, vout_d;
  logic             fdone_q, fdone_d;

  // Horizontal maxima of even rows, consumed by the odd row below; no reset needed
  fp32_t            row_buf_q [BUF_D];

  logic             in_beat;
  logic             odd_col;
  logic             odd_row;
  logic [IDX_W-1:0] buf_idx;
  fp32_t            buf_rd;
  fp32_t            h_max;
  fp32_t            v_max;
  fp32_t            pooled;

  assign in_beat = pool.Valid_In;
  assign odd_col = col_q[0];
  assign odd_row = row_q[0];
  assign buf_idx = IDX_W'(col_q >> 1);
  assign buf_rd  = row_buf_q[buf_idx];

  fp32_max2 u_hmax (.a_i(pair_q), .b_i(pool.Data_In), .max_o(h_max));
  fp32_max2 u_vmax (.a_i(h_max),  .b_i(buf_rd),       .max_o(v_max));

`ifdef RELU_FUSE_EN
  assign pooled = fp32_sign(v_max) ? FP32_POS_ZERO : v_max;
`else
  assign pooled = v_max;
`endif

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    fdone_d = 1'b0;
    if (in_beat) begin
      if (!odd_col) begin
        pair_d = pool.Data_In;
      end
      if (odd_col && odd_row) begin
        dout_d  = pooled;
        vout_d  = 1'b1;
        fdone_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= FP32_POS_ZERO;
      dout_q  <= FP32_POS_ZERO;
      vout_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      fdone_q <= fdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_beat && odd_col && !odd_row) begin
      row_buf_q[buf_idx] <= h_max;
    end
  end

  assign pool.Data_Out   = dout_q;
  assign pool.Valid_Out  = vout_q;
  assign pool.Frame_Done = fdone_q;

endmodule
